isqrt_share_arbiter: RTL and testbench

//  Shares one pipelined isqrt instance between N_REQ independent requesters
//  (e.g. several formula FSMs).
//  - Round-robin arbitration on the issue side.
//  - Tags every issued operation with its requester ID in an in-order tag FIFO.
//  - Steers each isqrt result back to the requester that issued it.
//  - Sits between the formula FSMs' isqrt_x/isqrt_y ports and the single isqrt.

---
 rtl/isqrt_share_arbiter.sv | 104 ++++++++++
 tb/tb_isqrt_share_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/isqrt_share_arbiter.sv
// Shares one pipelined isqrt between N_REQ requesters with round-robin issue and
// an in-order tag FIFO that steers each result back to the requester that issued it.
module isqrt_share_arbiter #(
    parameter int N_REQ        = 4,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req_vld,
    input  logic [N_REQ*32-1:0]             req_x,
    output logic [N_REQ-1:0]                req_rdy,
    output logic [N_REQ-1:0]                rsp_vld,
    output logic [15:0]                     rsp_y,
    output logic                            isqrt_x_vld,
    output logic [31:0]                     isqrt_x,
    input  logic                            isqrt_y_vld,
    input  logic [15:0]                     isqrt_y,
    output logic [$clog2(MAX_INFLIGHT):0]   inflight,
    output logic                            err_orphan
);

    localparam int PW  = $clog2(MAX_INFLIGHT);
    localparam int CW  = PW + 1;
    localparam int IDW = $clog2(N_REQ);

    logic [IDW-1:0] tag_mem [MAX_INFLIGHT];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] sel;
    logic           found;
    logic           can_issue;
    logic           push;
    logic           pop;
    logic           orphan;

    // Round-robin search starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin : sel_search
        int idx;
        idx   = 0;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_vld[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
    end

    // A result popping this cycle frees a slot, so a full FIFO can still accept a push.
    always_comb begin
        can_issue   = rst && ((count < CW'(MAX_INFLIGHT)) || isqrt_y_vld);
        push        = can_issue && found;
        pop         = isqrt_y_vld && (count != '0);
        orphan      = isqrt_y_vld && (count == '0);
        req_rdy     = push ? (N_REQ'(1) << sel) : '0;
        isqrt_x_vld = push;
        isqrt_x     = push ? req_x[32*sel +: 32] : '0;
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= sel;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (sel == IDW'(N_REQ - 1)) ? '0 : sel + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Orphan results are dropped: rsp_y keeps its old value and only the sticky flag records it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_vld    <= '0;
            rsp_y      <= '0;
            err_orphan <= 1'b0;
        end else begin
            rsp_vld <= pop ? (N_REQ'(1) << tag_mem[rd_ptr]) : '0;
            if (pop)    rsp_y      <= isqrt_y;
            if (orphan) err_orphan <= 1'b1;
        end
    end

    assign inflight = count;

endmodule

// File: tb/tb_isqrt_share_arbiter.sv
// Directed bench for isqrt_share_arbiter: grant order, tag steering, full FIFO,
// orphan results and asynchronous reset mid-stream.
module tb_isqrt_share_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_vld;
    logic [127:0] req_x;
    logic [3:0]   req_rdy;
    logic [3:0]   rsp_vld;
    logic [15:0]  rsp_y;
    logic         isqrt_x_vld;
    logic [31:0]  isqrt_x;
    logic         isqrt_y_vld;
    logic [15:0]  isqrt_y;
    logic [4:0]   inflight;
    logic         err_orphan;

    int vectors;
    int miscompares;

    isqrt_share_arbiter #(.N_REQ(4), .MAX_INFLIGHT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_x       (req_x),
        .req_rdy     (req_rdy),
        .rsp_vld     (rsp_vld),
        .rsp_y       (rsp_y),
        .isqrt_x_vld (isqrt_x_vld),
        .isqrt_x     (isqrt_x),
        .isqrt_y_vld (isqrt_y_vld),
        .isqrt_y     (isqrt_y),
        .inflight    (inflight),
        .err_orphan  (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    logic [3:0] exp_grant [5];
    int         exp_x     [5];

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_grant   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_x       = '{1, 2, 5, 10, 1};
        rst         = 1'b0;
        req_vld     = '0;
        req_x       = '0;
        isqrt_y_vld = 1'b0;
        isqrt_y     = '0;

        // Reset state
        #3;
        check_output("rst_rsp_vld", 32'(rsp_vld), 0);
        check_output("rst_rsp_y", 32'(rsp_y), 0);
        check_output("rst_inflight", 32'(inflight), 0);
        check_output("rst_err", 32'(err_orphan), 0);
        check_output("rst_req_rdy", 32'(req_rdy), 0);
        rst = 1'b1;
        tick();

        // Single request from requester 0
        req_vld = 4'b0001;
        req_x[31:0] = 32'd16;
        #1;
        check_output("single_rdy", 32'(req_rdy), 32'b0001);
        check_output("single_xvld", 32'(isqrt_x_vld), 1);
        check_output("single_x", isqrt_x, 16);
        tick();
        req_vld = 4'b0000;
        check_output("single_inflight", 32'(inflight), 1);
        isqrt_y_vld = 1'b1;
        isqrt_y     = 16'd4;
        #1;
        check_output("single_no_rdy", 32'(req_rdy), 0);
        tick();
        isqrt_y_vld = 1'b0;
        check_output("single_rsp_vld", 32'(rsp_vld), 32'b0001);
        check_output("single_rsp_y", 32'(rsp_y), 4);
        check_output("single_inflight0", 32'(inflight), 0);
        tick();
        check_output("single_rsp_idle", 32'(rsp_vld), 0);
        check_output("single_rsp_hold", 32'(rsp_y), 4);

        // Round robin with all four requesting
        apply_reset();
        tick();
        req_vld = 4'b1111;
        for (int i = 0; i < 4; i++) req_x[32*i +: 32] = 32'(i * i + 1);
        for (int g = 0; g < 5; g++) begin
            #1;
            check_output($sformatf("rr_grant%0d", g), 32'(req_rdy), 32'(exp_grant[g]));
            check_output($sformatf("rr_x%0d", g), isqrt_x, 32'(exp_x[g]));
            tick();
        end
        req_vld = 4'b0000;
        check_output("rr_inflight", 32'(inflight), 5);
        for (int k = 0; k < 5; k++) begin
            isqrt_y_vld = 1'b1;
            isqrt_y     = 16'(100 + k);
            tick();
            check_output($sformatf("rr_rsp_vld%0d", k), 32'(rsp_vld), 32'(exp_grant[k]));
            check_output($sformatf("rr_rsp_y%0d", k), 32'(rsp_y), 32'(100 + k));
        end
        isqrt_y_vld = 1'b0;
        #1;
        check_output("rr_drained", 32'(inflight), 0);

        // Fill the tag FIFO from requester 2
        apply_reset();
        tick();
        req_vld = 4'b0100;
        req_x[95:64] = 32'd7;
        for (int g = 0; g < 16; g++) begin
            #1;
            check_output($sformatf("full_grant%0d", g), 32'(req_rdy), 32'b0100);
            tick();
        end
        #1;
        check_output("full_inflight", 32'(inflight), 16);
        check_output("full_no_rdy", 32'(req_rdy), 0);
        check_output("full_no_xvld", 32'(isqrt_x_vld), 0);
        isqrt_y_vld = 1'b1;
        isqrt_y     = 16'd9;
        #1;
        check_output("full_pop_rdy", 32'(req_rdy), 32'b0100);
        check_output("full_pop_x", isqrt_x, 7);
        tick();
        isqrt_y_vld = 1'b0;
        check_output("full_pushpop_inflight", 32'(inflight), 16);
        check_output("full_rsp_vld", 32'(rsp_vld), 32'b0100);
        check_output("full_rsp_y", 32'(rsp_y), 9);
        #1;
        check_output("full_rdy_again0", 32'(req_rdy), 0);
        req_vld = 4'b0000;

        // Orphan result on empty FIFO
        apply_reset();
        tick();
        isqrt_y_vld = 1'b1;
        isqrt_y     = 16'd77;
        tick();
        isqrt_y_vld = 1'b0;
        check_output("orphan_rsp_vld", 32'(rsp_vld), 0);
        check_output("orphan_err", 32'(err_orphan), 1);
        check_output("orphan_rsp_y", 32'(rsp_y), 0);
        check_output("orphan_inflight", 32'(inflight), 0);
        tick();
        tick();
        check_output("orphan_sticky", 32'(err_orphan), 1);

        // Asynchronous reset with ops in flight
        apply_reset();
        tick();
        req_vld = 4'b0111;
        req_x[31:0]  = 32'd11;
        req_x[63:32] = 32'd22;
        req_x[95:64] = 32'd33;
        for (int g = 0; g < 3; g++) begin
            #1;
            check_output($sformatf("mid_grant%0d", g), 32'(req_rdy), 32'(4'b0001 << g));
            tick();
        end
        req_vld     = 4'b0000;
        isqrt_y_vld = 1'b1;
        isqrt_y     = 16'd55;
        tick();
        isqrt_y_vld = 1'b0;
        check_output("mid_rsp_vld", 32'(rsp_vld), 32'b0001);
        check_output("mid_inflight", 32'(inflight), 2);
        req_vld = 4'b0001;
        req_x[31:0] = 32'd3;
        #1;
        check_output("mid_wrap_grant", 32'(req_rdy), 32'b0001);
        rst = 1'b0;
        #1;
        check_output("arst_rsp_vld", 32'(rsp_vld), 0);
        check_output("arst_rsp_y", 32'(rsp_y), 0);
        check_output("arst_inflight", 32'(inflight), 0);
        check_output("arst_req_rdy", 32'(req_rdy), 0);
        check_output("arst_xvld", 32'(isqrt_x_vld), 0);
        check_output("arst_x", isqrt_x, 0);
        check_output("arst_err", 32'(err_orphan), 0);
        req_vld = 4'b0000;
        #1;
        rst = 1'b1;
        tick();
        isqrt_y_vld = 1'b1;
        isqrt_y     = 16'd66;
        tick();
        isqrt_y_vld = 1'b0;
        check_output("late_err", 32'(err_orphan), 1);
        check_output("late_rsp_vld", 32'(rsp_vld), 0);
        check_output("late_rsp_y", 32'(rsp_y), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
